// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU datapath comparators.
package alu_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    // Node count at a given level of the reduction tree; an odd node is carried up unchanged.
    function automatic int cmp_level_count(input int size, input int lvl);
        int c;
        c = size;
        for (int k = 0; k < lvl; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/cmp_merge.sv
// Merges a more-significant (hi) and less-significant (lo) compare pair into one.
module cmp_merge (
    input  logic i_gt_hi,
    input  logic i_eq_hi,
    input  logic i_gt_lo,
    input  logic i_eq_lo,
    output logic o_gt,
    output logic o_eq
);

    assign o_gt = i_gt_hi | (i_eq_hi & i_gt_lo);
    assign o_eq = i_eq_hi & i_eq_lo;

endmodule

// File: rtl/magnitude_comparator.sv
// Registered SIZE-bit magnitude comparator with unsigned and two's-complement modes.
// Flags come from a log-depth tree of cmp_merge nodes.
module magnitude_comparator
    import alu_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            signed_cmp,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    output logic            is_a_greater,
    output logic            equal,
    output logic            is_a_less
);

    localparam int LEVELS = $clog2(SIZE);

    logic            w_signed;
    logic [SIZE-1:0] w_leaf_gt;
    logic [SIZE-1:0] w_leaf_eq;
    logic            w_root_gt;
    logic            w_root_eq;
    cmp_flags_t      w_flags;
    cmp_flags_t      r_flags;
    logic            r_valid;

    assign w_signed = (signed_cmp == CMP_SIGNED);

    // In signed mode the sign bit inverts the sense of "greater" at the MSB only.
    for (genvar i = 0; i < SIZE; i++) begin : g_leaf
        if (i == SIZE - 1) begin : g_msb
            assign w_leaf_gt[i] = w_signed ? (~a[i] & b[i]) : (a[i] & ~b[i]);
        end else begin : g_bit
            assign w_leaf_gt[i] = a[i] & ~b[i];
        end
        assign w_leaf_eq[i] = ~(a[i] ^ b[i]);
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int PCNT = cmp_level_count(SIZE, l - 1);
        localparam int CNT  = cmp_level_count(SIZE, l);

        logic [PCNT-1:0] w_prev_gt;
        logic [PCNT-1:0] w_prev_eq;
        logic [CNT-1:0]  w_gt_l;
        logic [CNT-1:0]  w_eq_l;

        if (l == 1) begin : g_from_leaf
            assign w_prev_gt = w_leaf_gt;
            assign w_prev_eq = w_leaf_eq;
        end else begin : g_from_lvl
            assign w_prev_gt = g_lvl[l-1].w_gt_l;
            assign w_prev_eq = g_lvl[l-1].w_eq_l;
        end

        for (genvar n = 0; n < CNT; n++) begin : g_node
            if (2 * n + 1 < PCNT) begin : g_pair
                cmp_merge u_merge (
                    .i_gt_hi (w_prev_gt[2*n+1]),
                    .i_eq_hi (w_prev_eq[2*n+1]),
                    .i_gt_lo (w_prev_gt[2*n]),
                    .i_eq_lo (w_prev_eq[2*n]),
                    .o_gt    (w_gt_l[n]),
                    .o_eq    (w_eq_l[n])
                );
            end else begin : g_pass
                assign w_gt_l[n] = w_prev_gt[2*n];
                assign w_eq_l[n] = w_prev_eq[2*n];
            end
        end
    end

    if (LEVELS == 0) begin : g_root_leaf
        assign w_root_gt = w_leaf_gt[0];
        assign w_root_eq = w_leaf_eq[0];
    end else begin : g_root_tree
        assign w_root_gt = g_lvl[LEVELS].w_gt_l[0];
        assign w_root_eq = g_lvl[LEVELS].w_eq_l[0];
    end

    assign w_flags = {w_root_gt, w_root_eq, ~w_root_gt & ~w_root_eq};

    // Flags only load on a valid sample, so idle-cycle operand garbage never reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_flags <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid    = r_valid;
    assign is_a_greater = r_flags.gt;
    assign equal        = r_flags.eq;
    assign is_a_less    = r_flags.lt;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Randomised and directed bench for magnitude_comparator at SIZE = 1, 4, 8 and 13.
module tb_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, signed_cmp;
    logic [0:0]  a1,  b1;
    logic [3:0]  a4,  b4;
    logic [7:0]  a8,  b8;
    logic [12:0] a13, b13;
    logic ov1, g1, e1, l1;
    logic ov4, g4, e4, l4;
    logic ov8, g8, e8, l8;
    logic ov13, g13, e13, l13;

    int n_cmp = 0;
    int n_err = 0;

    magnitude_comparator #(.SIZE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_cmp(signed_cmp),
        .a(a1), .b(b1), .out_valid(ov1), .is_a_greater(g1), .equal(e1), .is_a_less(l1));
    magnitude_comparator #(.SIZE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_cmp(signed_cmp),
        .a(a4), .b(b4), .out_valid(ov4), .is_a_greater(g4), .equal(e4), .is_a_less(l4));
    magnitude_comparator #(.SIZE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_cmp(signed_cmp),
        .a(a8), .b(b8), .out_valid(ov8), .is_a_greater(g8), .equal(e8), .is_a_less(l8));
    magnitude_comparator #(.SIZE(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_cmp(signed_cmp),
        .a(a13), .b(b13), .out_valid(ov13), .is_a_greater(g13), .equal(e13), .is_a_less(l13));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as integers and compare arithmetically.
    function automatic logic [2:0] ref_cmp(input int n, input longint ua, input longint ub,
                                           input logic s);
        longint va, vb, half;
        va   = ua;
        vb   = ub;
        half = longint'(1) << (n - 1);
        if (s) begin
            if (ua >= half) va = ua - (longint'(1) << n);
            if (ub >= half) vb = ub - (longint'(1) << n);
        end
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // Drive one SIZE=4 sample at a negedge, check it at the next negedge.
    task automatic dir4(input string tag, input logic s, input logic [3:0] av,
                        input logic [3:0] bv, input logic [2:0] exp);
        in_valid   = 1'b1;
        signed_cmp = s;
        a4         = av;
        b4         = bv;
        @(negedge clk);
        chk({tag, "_v"}, 64'(ov4), 64'd1);
        chk(tag, 64'({g4, e4, l4}), 64'(exp));
    endtask

    task automatic dir1(input string tag, input logic s, input logic av, input logic bv,
                        input logic [2:0] exp);
        in_valid   = 1'b1;
        signed_cmp = s;
        a1         = av;
        b1         = bv;
        @(negedge clk);
        chk({tag, "_v"}, 64'(ov1), 64'd1);
        chk(tag, 64'({g1, e1, l1}), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] e_f [4];
        logic       e_v;
        logic       have_prev;
        logic [3:0] gel [4];
        logic       ovs [4];
        int         nb  [4];

        nb = '{1, 4, 8, 13};
        rst_n = 1'b0; in_valid = 1'b0; signed_cmp = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; a13 = '0; b13 = '0;
        repeat (3) @(negedge clk);
        chk("rst_v", 64'(ov4), 64'd0);
        chk("rst_flags", 64'({g4, e4, l4}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", 64'({ov4, g4, e4, l4}), 64'd0);

        dir4("u_0_0", 1'b0, 4'h0, 4'h0, 3'b010);
        dir4("u_1_0", 1'b0, 4'h1, 4'h0, 3'b100);
        dir4("u_0_1", 1'b0, 4'h0, 4'h1, 3'b001);
        dir4("u_F_0", 1'b0, 4'hF, 4'h0, 3'b100);
        dir4("u_F_F", 1'b0, 4'hF, 4'hF, 3'b010);
        dir4("s_F_0", 1'b1, 4'hF, 4'h0, 3'b001);
        dir4("s_7_8", 1'b1, 4'h7, 4'h8, 3'b100);
        dir4("s_8_8", 1'b1, 4'h8, 4'h8, 3'b010);
        dir4("s_8_7", 1'b1, 4'h8, 4'h7, 3'b001);
        dir1("w1_u_1_0", 1'b0, 1'b1, 1'b0, 3'b100);
        dir1("w1_s_1_0", 1'b1, 1'b1, 1'b0, 3'b001);

        // Hold: one valid sample, then idle cycles with changing operands.
        dir4("hold_load", 1'b0, 4'h3, 4'h2, 3'b100);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a4 = 4'(k); b4 = 4'hE; signed_cmp = 1'(k);
            @(negedge clk);
            chk("hold_v", 64'(ov4), 64'd0);
            chk("hold_flags", 64'({g4, e4, l4}), 64'b100);
        end

        // Reset between edges while samples stream.
        dir4("mid_pre", 1'b0, 4'h5, 4'h3, 3'b100);
        in_valid = 1'b1; a4 = 4'h9; b4 = 4'h2;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", 64'({ov4, g4, e4, l4}), 64'd0);
        @(negedge clk);
        chk("mid_rst_hold", 64'({ov4, g4, e4, l4}), 64'd0);
        rst_n = 1'b1;
        dir4("mid_post", 1'b0, 4'h2, 4'h9, 3'b001);

        have_prev = 1'b0;
        e_v = 1'b0;
        e_f = '{3'b000, 3'b000, 3'b000, 3'b000};
        for (int ph = 0; ph < 3; ph++) begin
            for (int it = 0; it < ((ph < 2) ? 1000 : 500); it++) begin
                @(negedge clk);
                if (have_prev) begin
                    ovs = '{ov1, ov4, ov8, ov13};
                    gel = '{{1'b0, g1, e1, l1}, {1'b0, g4, e4, l4},
                            {1'b0, g8, e8, l8}, {1'b0, g13, e13, l13}};
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("rnd_v_w%0d", nb[k]), 64'(ovs[k]), 64'(e_v));
                        chk($sformatf("rnd_flags_w%0d", nb[k]), 64'(gel[k][2:0]), 64'(e_f[k]));
                        if (ovs[k]) chk($sformatf("rnd_onehot_w%0d", nb[k]),
                                        64'($onehot(gel[k][2:0])), 64'd1);
                    end
                end
                in_valid   = (ph < 2) ? 1'b1 : 1'($urandom_range(0, 1));
                signed_cmp = (ph == 0) ? 1'b0 : (ph == 1) ? 1'b1 : 1'($urandom);
                a1  = 1'($urandom);  b1  = ($urandom_range(0, 7) == 0) ? a1  : 1'($urandom);
                a4  = 4'($urandom);  b4  = ($urandom_range(0, 7) == 0) ? a4  : 4'($urandom);
                a8  = 8'($urandom);  b8  = ($urandom_range(0, 7) == 0) ? a8  : 8'($urandom);
                a13 = 13'($urandom); b13 = ($urandom_range(0, 7) == 0) ? a13 : 13'($urandom);
                if (in_valid) begin
                    e_f[0] = ref_cmp(1,  longint'(a1),  longint'(b1),  signed_cmp);
                    e_f[1] = ref_cmp(4,  longint'(a4),  longint'(b4),  signed_cmp);
                    e_f[2] = ref_cmp(8,  longint'(a8),  longint'(b8),  signed_cmp);
                    e_f[3] = ref_cmp(13, longint'(a13), longint'(b13), signed_cmp);
                end
                e_v = in_valid;
                have_prev = 1'b1;
            end
        end
        @(negedge clk);
        chk("last_v", 64'(ov13), 64'(e_v));
        chk("last_flags", 64'({g13, e13, l13}), 64'(e_f[3]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
